// File: rtl/jtag_host_sequencer_if.sv
// Command/response bus between a JTAG host client and jtag_host_sequencer.
// The client drives commands and consumes responses; the sequencer is the slave side.
interface jtag_host_sequencer_if #(
    parameter int unsigned MAX_LEN = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [5:0]         cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_host_sequencer.sv
// Host-side JTAG master: turns TAP_RESET / SHIFT_IR / SHIFT_DR / IDLE commands into
// tck/tms/tdi step sequences and returns the tdo bits captured during shift steps.
module jtag_host_sequencer #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    jtag_host_sequencer_if.slave  io_bus,
    output logic                  o_tck,
    output logic                  o_tms,
    output logic                  o_tdi,
    output logic                  o_trst,
    input  logic                  i_tdo
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        OpTapReset = 2'b00,
        OpShiftIr  = 2'b01,
        OpShiftDr  = 2'b10,
        OpIdle     = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StStep = 2'b01,
        StResp = 2'b10
    } state_e;

    typedef struct packed {
        logic            tms;
        logic            shift;
        logic [IdxW-1:0] idx;
    } step_t;

    // Step k of a command; an extra leading TMS=0 step moves the TAP out of Test-Logic-Reset.
    function automatic step_t decode_step(op_e op, logic [6:0] n, logic extra, logic [6:0] k);
        step_t s;
        int    kk;
        int    hdr;
        int    ni;
        s  = '0;
        kk = int'(k);
        ni = int'(n);
        if (extra) begin
            if (kk == 0) begin
                return s;
            end
            kk = kk - 1;
        end
        hdr = (op == OpShiftIr) ? 4 : 3;
        case (op)
            OpTapReset: s.tms = (kk < 5);
            OpShiftIr, OpShiftDr: begin
                if (kk < hdr) begin
                    s.tms = (op == OpShiftIr) ? (kk < 2) : (kk == 0);
                end else if (kk < hdr + ni) begin
                    s.shift = 1'b1;
                    s.idx   = IdxW'(kk - hdr);
                    s.tms   = (kk == hdr + ni - 1);
                end else begin
                    s.tms = (kk == hdr + ni);
                end
            end
            default: s.tms = 1'b0;
        endcase
        return s;
    endfunction

    state_e             r_state;
    op_e                r_op;
    logic [6:0]         r_n;
    logic [6:0]         r_total;
    logic [6:0]         r_step;
    logic               r_extra;
    logic [MAX_LEN-1:0] r_data;
    logic [DivW-1:0]    r_div;
    logic               r_cur_shift;
    logic [IdxW-1:0]    r_cur_idx;
    logic               r_at_tlr;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic               r_trst;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [MAX_LEN-1:0] r_rsp_data;

    op_e        w_op;
    logic [6:0] w_len;
    logic [6:0] w_n;
    logic [6:0] w_total;
    logic       w_extra;
    step_t      w_first;
    step_t      w_next;

    always_comb begin
        w_op  = op_e'(io_bus.cmd_op);
        w_len = {1'b0, io_bus.cmd_len};
        if (w_len == 7'd0) begin
            w_n = 7'd1;
        end else if ({25'd0, w_len} > MAX_LEN) begin
            w_n = 7'(MAX_LEN);
        end else begin
            w_n = w_len;
        end
        w_extra = r_at_tlr && (w_op != OpTapReset);
        case (w_op)
            OpTapReset: w_total = 7'd6;
            OpShiftIr:  w_total = w_n + 7'd6 + {6'd0, w_extra};
            OpShiftDr:  w_total = w_n + 7'd5 + {6'd0, w_extra};
            default:    w_total = w_len + {6'd0, w_extra};
        endcase
        w_first = decode_step(w_op, w_n, w_extra, 7'd0);
        w_next  = decode_step(r_op, r_n, r_extra, r_step + 7'd1);
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_op        <= OpTapReset;
            r_n         <= 7'd0;
            r_total     <= 7'd0;
            r_step      <= 7'd0;
            r_extra     <= 1'b0;
            r_data      <= '0;
            r_div       <= '0;
            r_cur_shift <= 1'b0;
            r_cur_idx   <= '0;
            r_at_tlr    <= 1'b1;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_trst      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_trst <= 1'b1;
            case (r_state)
                StIdle: begin
                    if (r_cmd_ready && io_bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= w_op;
                        r_n         <= w_n;
                        r_total     <= w_total;
                        r_extra     <= w_extra;
                        r_data      <= io_bus.cmd_data;
                        r_step      <= 7'd0;
                        r_div       <= '0;
                        r_at_tlr    <= 1'b0;
                        r_rsp_data  <= '0;
                        r_tms       <= w_first.tms;
                        r_tdi       <= w_first.shift & io_bus.cmd_data[w_first.idx];
                        r_cur_shift <= w_first.shift;
                        r_cur_idx   <= w_first.idx;
                        r_state     <= StStep;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                StStep: begin
                    if (r_total == 7'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else if (r_div != DivLast) begin
                        r_div <= r_div + DivW'(1);
                    end else begin
                        r_div <= '0;
                        if (!r_tck) begin
                            r_tck <= 1'b1;
                            if (r_cur_shift) begin
                                r_rsp_data[r_cur_idx] <= i_tdo;
                            end
                        end else begin
                            r_tck <= 1'b0;
                            if (r_step + 7'd1 == r_total) begin
                                r_tms       <= 1'b0;
                                r_tdi       <= 1'b0;
                                r_cur_shift <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= StResp;
                            end else begin
                                r_step      <= r_step + 7'd1;
                                r_tms       <= w_next.tms;
                                r_tdi       <= w_next.shift & r_data[w_next.idx];
                                r_cur_shift <= w_next.shift;
                                r_cur_idx   <= w_next.idx;
                            end
                        end
                    end
                end
                StResp: begin
                    if (io_bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_tck            = r_tck;
    assign o_tms            = r_tms;
    assign o_tdi            = r_tdi;
    assign o_trst           = r_trst;
    assign io_bus.cmd_ready = r_cmd_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_jtag_host_sequencer.sv
// Bench for jtag_host_sequencer: TAP model with a 4-bit IR and a bypass DR, a
// scoreboard of expected tck steps and responses, and per-scenario tasks.
module tb_jtag_host_sequencer;

    localparam int CLK_DIV = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tck, tms, tdi, trst;
    logic tdo;

    jtag_host_sequencer_if #(.MAX_LEN(32)) bus ();

    jtag_host_sequencer #(.CLK_DIV(CLK_DIV), .MAX_LEN(32)) dut (
        .i_sys_clk (clk),
        .i_reset   (reset),
        .io_bus    (bus),
        .o_tck     (tck),
        .o_tms     (tms),
        .o_tdi     (tdi),
        .o_trst    (trst),
        .i_tdo     (tdo)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int e0     = 0;
    bit tb_at_tlr = 1'b1;

    int          exp_off_q[$];
    bit          exp_tms_q[$];
    bit          exp_tdi_q[$];
    logic [31:0] exp_rsp_q[$];
    int          exp_lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // TAP model
    typedef enum logic [3:0] {
        Tlr, Rti, SelDr, CapDr, ShDr, Ex1Dr, PauDr, Ex2Dr, UpdDr,
        SelIr, CapIr, ShIr, Ex1Ir, PauIr, Ex2Ir, UpdIr
    } tap_e;

    tap_e       tap_st;
    logic [3:0] ir;
    logic [3:0] ir_sr;
    logic       byp;
    logic [3:0] cap = 4'b0001;

    function automatic tap_e tap_next(tap_e s, logic m);
        case (s)
            Tlr:     return m ? Tlr   : Rti;
            Rti:     return m ? SelDr : Rti;
            SelDr:   return m ? SelIr : CapDr;
            CapDr:   return m ? Ex1Dr : ShDr;
            ShDr:    return m ? Ex1Dr : ShDr;
            Ex1Dr:   return m ? UpdDr : PauDr;
            PauDr:   return m ? Ex2Dr : PauDr;
            Ex2Dr:   return m ? UpdDr : ShDr;
            UpdDr:   return m ? SelDr : Rti;
            SelIr:   return m ? Tlr   : CapIr;
            CapIr:   return m ? Ex1Ir : ShIr;
            ShIr:    return m ? Ex1Ir : ShIr;
            Ex1Ir:   return m ? UpdIr : PauIr;
            PauIr:   return m ? Ex2Ir : PauIr;
            Ex2Ir:   return m ? UpdIr : ShIr;
            default: return m ? SelDr : Rti;
        endcase
    endfunction

    always @(posedge tck or negedge trst) begin
        if (!trst) begin
            tap_st <= Tlr;
            ir     <= 4'h1;
            ir_sr  <= 4'h0;
            byp    <= 1'b0;
        end else begin
            case (tap_st)
                CapIr:   ir_sr <= cap;
                ShIr:    ir_sr <= {tdi, ir_sr[3:1]};
                UpdIr:   ir    <= ir_sr;
                CapDr:   byp   <= 1'b0;
                ShDr:    byp   <= tdi;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck or negedge trst) begin
        if (!trst) tdo <= 1'b0;
        else tdo <= (tap_st == ShIr) ? ir_sr[0] : (tap_st == ShDr) ? byp : 1'b0;
    end

    // Step scoreboard: every tck rise is matched against the next expected step
    logic tck_prev = 1'b0;
    always @(negedge clk) begin : mon
        int off;
        bit et, ed;
        if (tck === 1'b1 && tck_prev === 1'b0) begin
            n_vec++;
            if (exp_off_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tck: rise at +%0d, required no rise", cyc - e0);
            end else begin
                off = exp_off_q.pop_front();
                et  = exp_tms_q.pop_front();
                ed  = exp_tdi_q.pop_front();
                if (tms !== et || tdi !== ed || cyc - e0 != off) begin
                    n_fail++;
                    $display("FAIL step_wave: got tms=%b tdi=%b at +%0d, required tms=%b tdi=%b at +%0d",
                             tms, tdi, cyc - e0, et, ed, off);
                end
            end
        end
        tck_prev = tck;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic push_step(inout int k, input bit t, input bit d);
        exp_off_q.push_back((2 * k + 1) * CLK_DIV);
        exp_tms_q.push_back(t);
        exp_tdi_q.push_back(d);
        k++;
    endtask

    task automatic push_expect(input logic [1:0] op, input int len, input logic [31:0] data);
        int n, k;
        logic [31:0] r;
        n = (len == 0) ? 1 : ((len > 32) ? 32 : len);
        k = 0;
        r = '0;
        if (tb_at_tlr && op != 2'b00) push_step(k, 1'b0, 1'b0);
        case (op)
            2'b00: begin
                for (int i = 0; i < 5; i++) push_step(k, 1'b1, 1'b0);
                push_step(k, 1'b0, 1'b0);
            end
            2'b01: begin
                push_step(k, 1'b1, 1'b0); push_step(k, 1'b1, 1'b0);
                push_step(k, 1'b0, 1'b0); push_step(k, 1'b0, 1'b0);
                for (int i = 0; i < n; i++) push_step(k, (i == n - 1), data[i]);
                push_step(k, 1'b1, 1'b0); push_step(k, 1'b0, 1'b0);
                for (int i = 0; i < n; i++) r[i] = (i < 4) ? cap[i] : data[i-4];
            end
            2'b10: begin
                push_step(k, 1'b1, 1'b0); push_step(k, 1'b0, 1'b0); push_step(k, 1'b0, 1'b0);
                for (int i = 0; i < n; i++) push_step(k, (i == n - 1), data[i]);
                push_step(k, 1'b1, 1'b0); push_step(k, 1'b0, 1'b0);
                for (int i = 1; i < n; i++) r[i] = data[i-1];
            end
            default: for (int i = 0; i < len; i++) push_step(k, 1'b0, 1'b0);
        endcase
        tb_at_tlr = 1'b0;
        exp_rsp_q.push_back(r);
        exp_lat_q.push_back((k == 0) ? 1 : 2 * k * CLK_DIV);
    endtask

    task automatic start_cmd(input logic [1:0] op, input int len, input logic [31:0] data);
        int t;
        push_expect(op, len, data);
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_len   = 6'(len);
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++; n_fail++;
            $display("FAIL handshake_timeout: cmd_ready=%b, required 1", bus.cmd_ready);
        end
        @(negedge clk);
        e0 = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] d);
        int t;
        logic [31:0] er;
        int el;
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        lat = cyc - e0;
        d   = bus.rsp_data;
        er  = exp_rsp_q.pop_front();
        el  = exp_lat_q.pop_front();
        n_vec++;
        if (t >= 3000) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b, required 1", bus.rsp_valid);
        end else if (d !== er) begin
            n_fail++;
            $display("FAIL rsp_data: got %h, required %h", d, er);
        end
        n_vec++;
        if (lat != el || exp_off_q.size() != 0) begin
            n_fail++;
            $display("FAIL rsp_latency: got +%0d with %0d steps missing, required +%0d with 0",
                     lat, exp_off_q.size(), el);
        end
        exp_off_q.delete(); exp_tms_q.delete(); exp_tdi_q.delete();
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_release: got rsp_valid=%b cmd_ready=%b, required 0 0",
                     bus.rsp_valid, bus.cmd_ready);
        end
        @(negedge clk);
        n_vec++;
        if (bus.cmd_ready !== 1'b1 || tck !== 1'b0 || tms !== 1'b0 || tap_st != Rti) begin
            n_fail++;
            $display("FAIL between_cmds: got cmd_ready=%b tck=%b tms=%b tap=%0d, required 1 0 0 %0d",
                     bus.cmd_ready, tck, tms, tap_st, Rti);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (tck !== 1'b0 || tms !== 1'b1 || trst !== 1'b0 || bus.cmd_ready !== 1'b0 ||
                bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state: got tck=%b tms=%b trst=%b rdy=%b rv=%b, required 0 1 0 0 0",
                         tck, tms, trst, bus.cmd_ready, bus.rsp_valid);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (trst !== 1'b1 || bus.cmd_ready !== 1'b1 || tms !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got trst=%b cmd_ready=%b tms=%b, required 1 1 1",
                     trst, bus.cmd_ready, tms);
        end
    endtask

    task automatic test_first_ir();
        int lat;
        logic [31:0] d;
        start_cmd(2'b01, 4, 32'h2);
        wait_rsp(lat, d);
        n_vec++;
        if (lat != 44 || d[1:0] !== 2'b01) begin
            n_fail++;
            $display("FAIL first_ir: got lat=%0d capture=%b, required 44 01", lat, d[1:0]);
        end
        finish_rsp();
        n_vec++;
        if (ir !== 4'h2) begin
            n_fail++;
            $display("FAIL first_ir_model: got ir=%h, required 2", ir);
        end
    endtask

    task automatic test_dr_bypass();
        int lat;
        logic [31:0] d;
        start_cmd(2'b10, 4, 32'hB);
        wait_rsp(lat, d);
        n_vec++;
        if (lat != 36 || d !== 32'h6) begin
            n_fail++;
            $display("FAIL dr_bypass: got lat=%0d data=%h, required 36 00000006", lat, d);
        end
        finish_rsp();
    endtask

    task automatic test_reset_idle();
        int lat;
        logic [31:0] d;
        start_cmd(2'b00, 0, 32'hFFFF_FFFF);
        wait_rsp(lat, d);
        finish_rsp();
        start_cmd(2'b11, 3, 32'hFFFF_FFFF);
        wait_rsp(lat, d);
        n_vec++;
        if (lat != 12 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL idle3: got lat=%0d data=%h, required 12 00000000", lat, d);
        end
        finish_rsp();
        start_cmd(2'b11, 0, 32'h0);
        wait_rsp(lat, d);
        n_vec++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL idle0: got lat=%0d, required 1", lat);
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] d;
        bit bad;
        start_cmd(2'b10, 8, 32'hA5);
        wait_rsp(lat, d);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.cmd_valid = (i == 3);
            bus.cmd_op    = 2'b11;
            bus.cmd_len   = 6'd5;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d || bus.cmd_ready !== 1'b0) bad = 1'b1;
        end
        bus.cmd_valid = 1'b0;
        n_vec++;
        if (bad) begin
            n_fail++;
            $display("FAIL backpressure: got rv=%b data=%h rdy=%b, required 1 %h 0",
                     bus.rsp_valid, bus.rsp_data, bus.cmd_ready, d);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] d;
        start_cmd(2'b10, 40, 32'hDEAD_BEEF);
        wait_rsp(lat, d);
        finish_rsp();
        start_cmd(2'b10, 0, 32'h1);
        wait_rsp(lat, d);
        finish_rsp();
        for (int i = 0; i < 4; i++) begin
            start_cmd(2'($urandom_range(1, 2)), int'($urandom_range(0, 40)), $urandom);
            wait_rsp(lat, d);
            finish_rsp();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] d;
        bit bad;
        start_cmd(2'b10, 32, $urandom);
        while (cyc < e0 + 10 * CLK_DIV) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (tck !== 1'b0 || tms !== 1'b1 || tdi !== 1'b0 || trst !== 1'b0 ||
            bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got tck=%b tms=%b tdi=%b trst=%b rdy=%b rv=%b, required 0 1 0 0 0 0",
                     tck, tms, tdi, trst, bus.cmd_ready, bus.rsp_valid);
        end
        exp_off_q.delete(); exp_tms_q.delete(); exp_tdi_q.delete();
        void'(exp_rsp_q.pop_front());
        void'(exp_lat_q.pop_front());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tb_at_tlr = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad || trst !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got stray rsp=%b trst=%b, required 0 1", bad, trst);
        end
        start_cmd(2'b10, 4, 32'h5);
        wait_rsp(lat, d);
        n_vec++;
        if (lat != 40) begin
            n_fail++;
            $display("FAIL post_reset_dr: got lat=%0d, required 40", lat);
        end
        finish_rsp();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = 6'd0;
        bus.cmd_data  = 32'h0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_first_ir();
        test_dr_bypass();
        test_reset_idle();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_host_sequencer.md
# jtag_host_sequencer

Host-side JTAG master in the `sys_clk` domain that sequences the on-chip TAP: it accepts high-level commands (TAP reset, shift IR, shift DR, idle clocks), generates `tck`/`tms`/`tdi`/`trst` wave sequences, and returns captured `tdo` bits. It lets on-chip self-test or a bring-up CPU drive halt/step/resume and boundary-scan instructions without an external probe.

## Interface
- `CLK_DIV`, default 2: `sys_clk` cycles per `tck` half-period. Minimum 1.
- `MAX_LEN`, default 32: maximum shift length in bits. Also the width of the data and response buses.
- `sys_clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_op`, in, 2: 00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE.
- `cmd_len`, in, 6: bit count (shift ops) or `tck` count (IDLE). For shift ops, 0 is treated as 1 and values above `MAX_LEN` saturate to `MAX_LEN`.
- `cmd_data`, in, MAX_LEN: data to shift, LSB first.
- `rsp_valid`, out, 1: response available.
- `rsp_ready`, in, 1: response consumed.
- `rsp_data`, out, MAX_LEN: captured `tdo`. Bit i is the bit captured during shift step i; unused upper bits are 0. Always 0 for TAP_RESET and IDLE.
- `tck`, out, 1: TAP clock.
- `tms`, out, 1: TAP mode select.
- `tdi`, out, 1: TAP data in.
- `trst`, out, 1: active-low TAP reset.
- `tdo`, in, 1: TAP data out.

## Operation
- Every output is a flop.
- Reset values: `tck`=0, `tms`=1, `tdi`=0, `trst`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0.
- `trst` rises and `cmd_ready` rises on the first `sys_clk` edge after `reset` deasserts.
- Internal flag `at_tlr` is set by reset. While it is set, the TAP is taken to be in Test-Logic-Reset.
- Every other command starts and ends in Run-Test/Idle (RTI).
- FSM states:
  - IDLE: `cmd_ready`=1.
  - STEP: issues one `tck` period with a given `tms`/`tdi`, driven by a step list.
  - RESP: `rsp_valid`=1 until `rsp_ready`.
- Step lists (TMS values, one per `tck` period):
  - TAP_RESET: 1,1,1,1,1,0 (6 steps). Ends in RTI and clears `at_tlr`.
  - SHIFT_IR: header 1,1,0,0; then N shift steps with TMS=0 except the last step, which has TMS=1; then trailer 1,0. Total N+6 steps.
  - SHIFT_DR: header 1,0,0; N shift steps as above; trailer 1,0. Total N+5 steps.
  - IDLE: `cmd_len` steps with TMS=0. `cmd_len`=0 produces no steps and goes straight to RESP.
- If `at_tlr` is set, SHIFT_IR, SHIFT_DR and IDLE get one extra leading TMS=0 step, and `at_tlr` is cleared.
- During shift steps, `tdi` = `cmd_data[i]`. Outside shift steps, `tdi`=0.
- `tdo` is sampled into `rsp_data[i]` on the `sys_clk` edge at which `tck` rises during shift step i.
- `cmd_ready` = state is IDLE and `rsp_valid` is low. The command is latched on handshake.
- `cmd_valid` while busy is ignored. There is no queueing.

## Timing
- Each step is 2·`CLK_DIV` `sys_clk` cycles: `tck` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
- `tms`/`tdi` update only on the edge where `tck` falls, or on the handshake edge for step 0.
- Let E0 be the handshake edge. For a command of S steps:
  - Step k drives `tms`/`tdi` at E0 + 2k·`CLK_DIV`.
  - `tck` rises at E0 + (2k+1)·`CLK_DIV`.
  - `rsp_valid` rises with the final `tck` fall at E0 + 2S·`CLK_DIV`.
- IDLE with `cmd_len`=0: `rsp_valid` rises at E0+1.
- `rsp_valid` and `rsp_data` hold stable until `rsp_ready`. `rsp_valid` clears on the edge where `rsp_valid` and `rsp_ready` are both high. `cmd_ready` rises on the next edge.
- Between commands: `tck`=0 and `tms`=0 (RTI). `tms`=1 only after reset.
- Reset mid-command: outputs return to reset values immediately. Any response in progress is discarded. `at_tlr` is set.

## Test plan
- Reset:
  - Hold `reset` 3 cycles, then release.
  - `tck`=0, `tms`=1, `trst`=0 during reset.
  - `trst`=1 and `cmd_ready`=1 one edge after release.
- First command after reset:
  - SHIFT_IR, len=4, data=0x2, `CLK_DIV`=2, TAP model attached.
  - TMS sequence 0,1,1,0,0,0,0,0,1,1,0 (11 steps). `tdi` shift bits 0,1,0,0.
  - `rsp_valid` at E0+44. Model IR holds 0x2.
  - `rsp_data[1:0]`=01 (IR capture pattern).
- SHIFT_DR with a bypass model:
  - len=4, data=0b1011, bypass model (capture 0, one-bit delay).
  - `rsp_data`=0b0110. 9 steps. `rsp_valid` at E0+36.
- TAP_RESET, then IDLE:
  - TAP_RESET: TMS 1,1,1,1,1,0.
  - IDLE len=3: 3 `tck` periods with TMS=0, `rsp_data`=0.
  - IDLE len=0: `rsp_valid` at E0+1 and no `tck` pulse.
- Response backpressure:
  - Hold `rsp_ready`=0 for 10 cycles after `rsp_valid`.
  - `rsp_data` stable, `cmd_ready`=0, and a `cmd_valid` pulse is ignored.
  - `cmd_ready` rises one edge after `rsp_ready`.
- Reset mid-shift:
  - Assert `reset` during step 5 of a len=32 SHIFT_DR.
  - Outputs return to reset values asynchronously and no `rsp_valid` appears.
  - The next SHIFT_DR gets the extra leading TMS=0 step.
